// File: rtl/a_ctrls_encode.sv
// Serialises seven snapshot bytes as an ASCII "MEAS:hh,hh,...,hh\r\n" frame
// over a valid/ready byte stream toward a UART transmitter.
module a_ctrls_encode #(
    parameter bit UPPERCASE = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [0:6][7:0] values,
    input  logic            send,
    output logic            busy,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic            frame_done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_HI   = 3'd2;
    localparam logic [2:0] S_LO   = 3'd3;
    localparam logic [2:0] S_SEP  = 3'd4;
    localparam logic [2:0] S_CR   = 3'd5;
    localparam logic [2:0] S_LF   = 3'd6;

    logic [2:0]       state;
    logic [2:0]       hdr_cnt;
    logic [2:0]       idx;
    logic [0:6][7:0]  snap;
    logic [7:0]       cur_byte;
    logic [7:0]       hdr_char;
    logic             xfer;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return (UPPERCASE ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
    endfunction

    assign xfer     = tx_valid & tx_ready;
    assign tx_valid = (state != S_IDLE);
    assign busy     = (state != S_IDLE);

    always_comb begin
        cur_byte = 8'h00;
        if (idx <= 3'd6)
            cur_byte = snap[idx];
    end

    always_comb begin
        case (hdr_cnt)
            3'd0:    hdr_char = 8'h4D;  // M
            3'd1:    hdr_char = 8'h45;  // E
            3'd2:    hdr_char = 8'h41;  // A
            3'd3:    hdr_char = 8'h53;  // S
            default: hdr_char = 8'h3A;  // :
        endcase
    end

    // Output byte is a pure function of registered state, so it holds during stalls.
    always_comb begin
        case (state)
            S_HDR:   tx_data = hdr_char;
            S_HI:    tx_data = hex_ascii(cur_byte[7:4]);
            S_LO:    tx_data = hex_ascii(cur_byte[3:0]);
            S_SEP:   tx_data = 8'h2C;
            S_CR:    tx_data = 8'h0D;
            S_LF:    tx_data = 8'h0A;
            default: tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            hdr_cnt    <= 3'd0;
            idx        <= 3'd0;
            snap       <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: if (send) begin
                    snap    <= values;
                    hdr_cnt <= 3'd0;
                    idx     <= 3'd0;
                    state   <= S_HDR;
                end
                S_HDR: if (xfer) begin
                    if (hdr_cnt == 3'd4)
                        state <= S_HI;
                    else
                        hdr_cnt <= hdr_cnt + 3'd1;
                end
                S_HI: if (xfer) state <= S_LO;
                S_LO: if (xfer) state <= (idx == 3'd6) ? S_CR : S_SEP;
                S_SEP: if (xfer) begin
                    idx   <= idx + 3'd1;
                    state <= S_HI;
                end
                S_CR: if (xfer) state <= S_LF;
                S_LF: if (xfer) begin
                    state      <= S_IDLE;
                    hdr_cnt    <= 3'd0;
                    idx        <= 3'd0;
                    frame_done <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a_ctrls_encode.sv
// Directed bench for a_ctrls_encode: table frames in both hex cases, stalls,
// ignored sends, mid-frame reset, reset release with send held, loopback decode.
module tb_a_ctrls_encode;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [0:6][7:0] values;
    logic            send;
    logic            tx_ready = 1'b1;
    logic            busy_u, tx_valid_u, fd_u;
    logic [7:0]      tx_data_u;
    logic            busy_l, tx_valid_l, fd_l;
    logic [7:0]      tx_data_l;

    always #5 clk = ~clk;

    a_ctrls_encode #(.UPPERCASE(1'b1)) u_up (
        .clk(clk), .reset_n(reset_n), .values(values), .send(send), .busy(busy_u),
        .tx_data(tx_data_u), .tx_valid(tx_valid_u), .tx_ready(tx_ready), .frame_done(fd_u));

    a_ctrls_encode #(.UPPERCASE(1'b0)) u_lo (
        .clk(clk), .reset_n(reset_n), .values(values), .send(send), .busy(busy_l),
        .tx_data(tx_data_l), .tx_valid(tx_valid_l), .tx_ready(tx_ready), .frame_done(fd_l));

    bit         rnd_ready = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] cap_u[$];
    logic [7:0] cap_l[$];
    logic       stall_p = 1'b0;
    logic [7:0] stall_d = 8'h00;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        tx_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Transfer capture and stall-hold check, sampled mid-cycle.
    always @(negedge clk) begin
        if (stall_p)
            chk(tx_valid_u && tx_data_u == stall_d, "stall_hold", {55'd0, tx_valid_u, tx_data_u}, {55'd0, 1'b1, stall_d});
        stall_p = reset_n && tx_valid_u && !tx_ready;
        stall_d = tx_data_u;
        if (reset_n && tx_valid_u && tx_ready) cap_u.push_back(tx_data_u);
        if (reset_n && tx_valid_l && tx_ready) cap_l.push_back(tx_data_l);
    end

    typedef struct {
        logic [0:6][7:0] v;
        string           up;
        string           lo;
        bit              rr;
    } vec_t;

    vec_t tbl[4];

    task automatic check_frame(input string nm, input string e, input logic [7:0] q[$]);
        logic [7:0] ev;
        int         bad;
        chk(q.size() == 27, {nm, "_len"}, 64'(q.size()), 64'd27);
        bad = -1;
        for (int i = 0; i < 27 && i < q.size(); i++) begin
            ev = (i < 25) ? e.getc(i) : ((i == 25) ? 8'h0D : 8'h0A);
            if (bad < 0 && q[i] !== ev) bad = i;
        end
        if (bad >= 0) begin
            ev = (bad < 25) ? e.getc(bad) : ((bad == 25) ? 8'h0D : 8'h0A);
            chk(1'b0, $sformatf("%s_byte%0d", nm, bad), 64'(q[bad]), 64'(ev));
        end else
            chk(1'b1, {nm, "_bytes"}, 64'd0, 64'd0);
    endtask

    task automatic start_frame(input logic [0:6][7:0] v);
        @(negedge clk); #1;
        cap_u.delete();
        cap_l.delete();
        values = v;
        send   = 1'b1;
        @(negedge clk); #1;
        send = 1'b0;
    endtask

    // Starts at the first negedge after the accepting edge (n=1).
    task automatic wait_done(output int n);
        n = 1;
        while (!fd_u && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        if (!fd_u) chk(1'b0, "frame_done_timeout", 64'(n), 64'd28);
    endtask

    function automatic int hexv(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 32'h30;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 32'h41 + 10;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 32'h61 + 10;
        return -1;
    endfunction

    // Independent MEAS frame decoder, accepts either hex case.
    function automatic bit decode(input logic [7:0] q[$], output logic [0:6][7:0] v);
        string hdr;
        int    p, hi, lo;
        hdr = "MEAS:";
        v = '0;
        if (q.size() != 27) return 1'b0;
        for (int i = 0; i < 5; i++) if (q[i] != hdr.getc(i)) return 1'b0;
        for (int i = 0; i < 7; i++) begin
            p  = 5 + 3 * i;
            hi = hexv(q[p]);
            lo = hexv(q[p + 1]);
            if (hi < 0 || lo < 0) return 1'b0;
            v[i] = 8'((hi << 4) | lo);
            if (q[p + 2] != ((i < 6) ? 8'h2C : 8'h0D)) return 1'b0;
        end
        return q[26] == 8'h0A;
    endfunction

    initial begin
        int              n, k;
        logic [0:6][7:0] rv, dv;
        bit              ok;

        tbl[0].v = {8'h00, 8'h01, 8'h7F, 8'h80, 8'hA5, 8'hFE, 8'hFF};
        tbl[0].up = "MEAS:00,01,7F,80,A5,FE,FF"; tbl[0].lo = "MEAS:00,01,7f,80,a5,fe,ff"; tbl[0].rr = 1'b0;
        tbl[1].v = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE};
        tbl[1].up = "MEAS:12,34,56,78,9A,BC,DE"; tbl[1].lo = "MEAS:12,34,56,78,9a,bc,de"; tbl[1].rr = 1'b0;
        tbl[2].v = {7{8'hFF}};
        tbl[2].up = "MEAS:FF,FF,FF,FF,FF,FF,FF"; tbl[2].lo = "MEAS:ff,ff,ff,ff,ff,ff,ff"; tbl[2].rr = 1'b0;
        tbl[3] = tbl[0];
        tbl[3].rr = 1'b1;

        reset_n = 1'b0;
        send    = 1'b0;
        values  = '0;
        @(negedge clk); #1;
        chk(!busy_u, "reset_busy", 64'(busy_u), 64'd0);
        chk(!tx_valid_u, "reset_tx_valid", 64'(tx_valid_u), 64'd0);
        chk(tx_data_u == 8'h00, "reset_tx_data", 64'(tx_data_u), 64'd0);
        chk(!fd_u, "reset_frame_done", 64'(fd_u), 64'd0);
        reset_n = 1'b1;

        for (int t = 0; t < 4; t++) begin
            rnd_ready = tbl[t].rr;
            start_frame(tbl[t].v);
            chk(busy_u && tx_valid_u && tx_data_u == 8'h4D, $sformatf("t%0d_first_M", t), 64'(tx_data_u), 64'h4D);
            wait_done(n);
            if (!tbl[t].rr) chk(n == 28, $sformatf("t%0d_done_latency", t), 64'(n), 64'd28);
            check_frame($sformatf("t%0d_upper", t), tbl[t].up, cap_u);
            check_frame($sformatf("t%0d_lower", t), tbl[t].lo, cap_l);
            @(negedge clk); #1;
            chk(!busy_u && !tx_valid_u && !fd_u, $sformatf("t%0d_idle_after", t),
                {61'd0, busy_u, tx_valid_u, fd_u}, 64'd0);
        end
        rnd_ready = 1'b0;

        // Sends during the frame and at the LF edge are ignored; values change mid-frame.
        start_frame(tbl[1].v);
        n = 1;
        do begin
            @(negedge clk); #1;
            n++;
            if (cap_u.size() >= 3) values = tbl[2].v;
            send = (cap_u.size() == 10) || (tx_valid_u && tx_data_u == 8'h0A);
        end while (!fd_u && n < 400);
        send = 1'b0;
        chk(fd_u, "ign_done_seen", 64'(fd_u), 64'd1);
        check_frame("ign_frame", tbl[1].up, cap_u);
        @(negedge clk); #1;
        chk(!busy_u, "ign_send_at_lf", 64'(busy_u), 64'd0);

        // Reset mid-frame aborts it.
        start_frame(tbl[0].v);
        n = 0;
        while (cap_u.size() < 12 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        #1;
        reset_n = 1'b0;
        #1;
        chk(!tx_valid_u, "rst_mid_valid", 64'(tx_valid_u), 64'd0);
        chk(!busy_u, "rst_mid_busy", 64'(busy_u), 64'd0);
        chk(tx_data_u == 8'h00, "rst_mid_data", 64'(tx_data_u), 64'd0);
        k = cap_u.size();
        @(negedge clk); #1;
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk(cap_u.size() == k, "rst_no_more_bytes", 64'(cap_u.size()), 64'(k));
        chk(!busy_u, "rst_stays_idle", 64'(busy_u), 64'd0);
        start_frame(tbl[0].v);
        wait_done(n);
        check_frame("rst_fresh_frame", tbl[0].up, cap_u);

        // Release reset with send held: frame starts on first edge out of reset.
        @(negedge clk); #1;
        reset_n = 1'b0;
        send    = 1'b1;
        values  = tbl[1].v;
        cap_u.delete();
        cap_l.delete();
        @(negedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk); #1;
        chk(busy_u && tx_data_u == 8'h4D, "rel_send_start", 64'(tx_data_u), 64'h4D);
        send = 1'b0;
        wait_done(n);
        check_frame("rel_send_frame", tbl[1].up, cap_u);

        // Loopback through the decoder with random values.
        for (int f = 0; f < 1000; f++) begin
            for (int b = 0; b < 7; b++) rv[b] = 8'($urandom);
            rnd_ready = (f % 8 == 0);
            start_frame(rv);
            wait_done(n);
            ok = decode(cap_u, dv);
            chk(ok && dv == rv, $sformatf("loop%0d_upper", f), 64'(dv), 64'(rv));
            ok = decode(cap_l, dv);
            chk(ok && dv == rv, $sformatf("loop%0d_lower", f), 64'(dv), 64'(rv));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
